// File: rtl/seq_detector.sv
// Serial-bit sequence detector: synchronised switch inputs, HIST_W-bit history, programmable pattern match.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 HIST_W  = 16,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                FILL_W  = $clog2(HIST_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              clear,
    output logic [HIST_W-1:0] history,
    output logic [FILL_W-1:0] fill,
    output logic              has_input,
    output logic              match,
    output logic              match_led,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int SINCE_W = $clog2(PAT_LEN + 1);

    logic               bv1, bv2, bs1, bs2, prev, armed;
    logic [1:0]         boot;
    logic [SINCE_W-1:0] since;

    logic [HIST_W-1:0]  hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic [SINCE_W-1:0] since_inc;
    logic               accept;
    logic               hit;

    // boot marks when bv2 holds a real sample, so a switch held high through
    // reset cannot look like a fresh rising edge; armed needs a genuine low first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bv1   <= 1'b0;
            bv2   <= 1'b0;
            bs1   <= 1'b0;
            bs2   <= 1'b0;
            prev  <= 1'b0;
            boot  <= 2'b00;
            armed <= 1'b0;
        end else begin
            bv1  <= bit_valid;
            bv2  <= bv1;
            bs1  <= bit_in;
            bs2  <= bs1;
            prev <= bv2;
            boot <= {boot[0], 1'b1};
            if (boot[1] && !bv2) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        hist_shift = {history[HIST_W-2:0], bs2};
        fill_inc   = (fill == FILL_W'(HIST_W)) ? fill : fill + FILL_W'(1);
        since_inc  = (since == SINCE_W'(PAT_LEN)) ? since : since + SINCE_W'(1);
        accept     = bv2 && !prev && armed;
        hit        = accept
                     && (hist_shift[PAT_LEN-1:0] == PATTERN)
                     && (since_inc == SINCE_W'(PAT_LEN));
    end

    // since counts bits since the last consumed match; it only resets on a match when overlap is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history   <= '0;
            fill      <= '0;
            since     <= '0;
            has_input <= 1'b0;
            match     <= 1'b0;
            match_led <= 1'b0;
        end else begin
            has_input <= accept && !clear;
            match     <= hit && !clear;
            if (clear) begin
                history   <= '0;
                fill      <= '0;
                since     <= '0;
                match_led <= 1'b0;
            end else if (accept) begin
                history <= hist_shift;
                fill    <= fill_inc;
                since   <= (hit && (OVERLAP == 0)) ? '0 : since_inc;
                if (hit) begin
                    match_led <= 1'b1;
                end
            end
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
